// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: FSM encodings and
// the default carried word width.
package pipe_pkg;

    localparam int DATA_WIDTH = 32;

    // 2'b11 is unused; the control FSM recovers from it to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        MAIN  = 2'b01,
        BOTH  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_register_storage.sv
// Parameterised storage register with load enable; clears to zero on reset.
module pipe_skid_register_storage #(
    parameter int size = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [size-1:0] d,
    output logic [size-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_register.sv
// Elastic pipeline register with a two-entry skid buffer so that inReady is
// a flop while throughput stays at one word per cycle.
//
// Handshake: a word moves across an interface on a rising clock edge where
// both valid and ready are high; valid and data must stay put until that
// edge, and the producer must not derive inValid/regIn from inReady.
module pipe_skid_register
    import pipe_pkg::*;
#(
    parameter int size = DATA_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic [size-1:0] regIn,
    output logic            outValid,
    input  logic            outReady,
    output logic [size-1:0] regOut,
    input  logic            flush
);

    skid_state_t     state;
    skid_state_t     state_next;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            accept;
    logic            deliver;
    logic            load_main;
    logic            load_skid;
    logic            main_sel_skid;
    logic [size-1:0] main_d;
    logic [size-1:0] main_q;
    logic [size-1:0] skid_q;

    assign accept   = inValid & in_ready_q;
    assign deliver  = out_valid_q & outReady;
    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign regOut   = main_q;
    assign main_d   = main_sel_skid ? skid_q : regIn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= state_next;
            out_valid_q <= (state_next != EMPTY);
            in_ready_q  <= (state_next != BOTH);
        end
    end

    // Flush overrides everything; regOut keeps its stale value.
    always_comb begin
        state_next    = state;
        load_main     = 1'b0;
        load_skid     = 1'b0;
        main_sel_skid = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = MAIN;
                        load_main  = 1'b1;
                    end
                end
                MAIN: begin
                    if (accept && deliver) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_next = BOTH;
                        load_skid  = 1'b1;
                    end else if (deliver) begin
                        state_next = EMPTY;
                    end
                end
                BOTH: begin
                    if (deliver) begin
                        state_next    = MAIN;
                        load_main     = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    pipe_skid_register_storage #(.size(size)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (load_main),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_skid_register_storage #(.size(size)) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (load_skid),
        .d     (regIn),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_register.sv
// Directed and randomised checks of pipe_skid_register against hand-computed
// values and an occupancy/ordering scoreboard.
module tb_pipe_skid_register;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] regIn;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] regOut;
    logic         flush;

    int checks;
    int failures;
    logic [W-1:0] exp_q[$];

    pipe_skid_register #(.size(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .regIn    (regIn),
        .outValid (outValid),
        .outReady (outReady),
        .regOut   (regOut),
        .flush    (flush)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        inValid  = v;
        regIn    = d;
        outReady = r;
        flush    = f;
    endtask

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_io(input string tag, input logic v, input logic r, input logic [W-1:0] d);
        check({tag, "_outValid"}, W'(outValid), W'(v));
        check({tag, "_inReady"}, W'(inReady), W'(r));
        check({tag, "_regOut"}, regOut, d);
    endtask

    initial begin
        logic acc;
        logic del;
        logic [W-1:0] stream [4];
        checks   = 0;
        failures = 0;
        stream[0] = 32'h1;
        stream[1] = 32'h2;
        stream[2] = 32'h3;
        stream[3] = 32'h4;

        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        check_io("reset", 1'b0, 1'b1, 32'h0);
        reset = 1'b0;

        // first word: one edge of latency
        drive(1'b1, 32'h5, 1'b1, 1'b0);
        step();
        check_io("first", 1'b1, 1'b1, 32'h5);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("first_drain_outValid", W'(outValid), 32'h0);

        // back-to-back streaming, no bubbles
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, stream[i], 1'b1, 1'b0);
            step();
            check_io($sformatf("stream%0d", i), 1'b1, 1'b1, stream[i]);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("stream_drain_outValid", W'(outValid), 32'h0);

        // backpressure fills the skid entry
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step();
        check_io("bp_a", 1'b1, 1'b1, 32'hA);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step();
        check_io("bp_b", 1'b1, 1'b0, 32'hA);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check_io("bp_rel", 1'b1, 1'b1, 32'hB);
        step();
        check_io("bp_empty", 1'b0, 1'b1, 32'hB);

        // flush while BOTH holds A/B and C is offered
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step();
        check("fl_pre_inReady", W'(inReady), 32'h0);
        drive(1'b1, 32'hC, 1'b0, 1'b1);
        step();
        check_io("flush", 1'b0, 1'b1, 32'hA);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check_io("flush_after", 1'b0, 1'b1, 32'hA);

        // asynchronous reset between edges
        drive(1'b1, 32'h7, 1'b0, 1'b0);
        step();
        check_io("ar_pre", 1'b1, 1'b1, 32'h7);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_io("async_reset", 1'b0, 1'b1, 32'h0);
        #1;
        reset = 1'b0;
        step();
        check_io("ar_post", 1'b0, 1'b1, 32'h0);

        // random traffic against the scoreboard
        exp_q.delete();
        for (int c = 0; c < 1000; c++) begin
            check("rnd_outValid", W'(outValid), W'(exp_q.size() != 0));
            check("rnd_inReady", W'(inReady), W'(exp_q.size() != 2));
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 49) == 0));
            acc = inValid & inReady;
            del = outValid & outReady;
            if (del && !flush) begin
                if (exp_q.size() == 0) begin
                    check("rnd_deliver_empty", W'(1), W'(0));
                end else begin
                    check("rnd_data", regOut, exp_q[0]);
                end
            end
            step();
            if (flush) begin
                exp_q.delete();
            end else begin
                if (del && exp_q.size() != 0) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(regIn);
            end
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
